// File: rtl/gpio_bank_pkg.sv
// Shared register offsets and helpers for the iomem GPIO bank.
package gpio_bank_pkg;

    localparam int WINDOW_BITS = 5;

    localparam logic [2:0] REG_OUT   = 3'd0;
    localparam logic [2:0] REG_IN    = 3'd1;
    localparam logic [2:0] REG_BTN   = 3'd2;
    localparam logic [2:0] REG_EDGE  = 3'd3;
    localparam logic [2:0] REG_IRQEN = 3'd4;

    // Expand the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button bit: synchroniser chain, stability counter and accepted level with a rise pulse.
module debounce_cell #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   differ;
    logic                   expire;

    assign differ = sync[SYNC_STAGES-1] ^ level;
    assign expire = differ && (cnt == CNT_MAX);
    // Combinational so the edge flag lands on the same clock as the level change.
    assign rise   = expire && !level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (!differ) begin
                cnt <= '0;
            end else if (expire) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/iomem_gpio_bank.sv
// iomem-bus GPIO slave: LED output register, synchronised switches, debounced buttons with edge flags and IRQ.
module iomem_gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
    parameter int          IN_WIDTH        = 16,
    parameter int          BTN_WIDTH       = 5,
    parameter int          OUT_WIDTH       = 16,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iomem_valid,
    output logic                 iomem_ready,
    input  logic [3:0]           iomem_wstrb,
    input  logic [31:0]          iomem_addr,
    input  logic [31:0]          iomem_wdata,
    output logic [31:0]          iomem_rdata,
    input  logic [IN_WIDTH-1:0]  sw_in,
    input  logic [BTN_WIDTH-1:0] btn_in,
    output logic [OUT_WIDTH-1:0] gpio_out,
    output logic                 irq
);

    logic                 hit;
    logic                 is_write;
    logic [2:0]           offset;
    logic [31:0]          byte_mask;
    logic [31:0]          rd_val;
    logic [BTN_WIDTH-1:0] edge_clr;
    logic [BTN_WIDTH-1:0] btn_level;
    logic [BTN_WIDTH-1:0] btn_rise;
    logic [BTN_WIDTH-1:0] edge_q;
    logic [BTN_WIDTH-1:0] irq_en;
    logic [IN_WIDTH-1:0]  sw_sync [SYNC_STAGES];
    logic                 unused_bits;

    // The !iomem_ready term turns a held request into a two-cycle access.
    assign hit       = iomem_valid && !iomem_ready &&
                       (iomem_addr[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
    assign is_write  = |iomem_wstrb;
    assign offset    = iomem_addr[4:2];
    assign byte_mask = strb_to_mask(iomem_wstrb);
    assign edge_clr  = (hit && is_write && offset == REG_EDGE) ?
                       (iomem_wdata[BTN_WIDTH-1:0] & byte_mask[BTN_WIDTH-1:0]) : '0;

    assign unused_bits = ^{iomem_addr[1:0], iomem_wdata, byte_mask};

    for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_btn
        debounce_cell #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .din  (btn_in[g]),
            .level(btn_level[g]),
            .rise (btn_rise[g])
        );
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            REG_OUT:   rd_val = 32'(gpio_out);
            REG_IN:    rd_val = 32'(sw_sync[SYNC_STAGES-1]);
            REG_BTN:   rd_val = 32'(btn_level);
            REG_EDGE:  rd_val = 32'(edge_q);
            REG_IRQEN: rd_val = 32'(irq_en);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= '0;
            end
        end else begin
            sw_sync[0] <= sw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= sw_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            gpio_out    <= '0;
            irq_en      <= '0;
            edge_q      <= '0;
            irq         <= 1'b0;
        end else begin
            iomem_ready <= hit;
            iomem_rdata <= hit ? rd_val : '0;
            if (hit && is_write && offset == REG_OUT) begin
                gpio_out <= (gpio_out & ~byte_mask[OUT_WIDTH-1:0]) |
                            (iomem_wdata[OUT_WIDTH-1:0] & byte_mask[OUT_WIDTH-1:0]);
            end
            if (hit && is_write && offset == REG_IRQEN) begin
                irq_en <= (irq_en & ~byte_mask[BTN_WIDTH-1:0]) |
                          (iomem_wdata[BTN_WIDTH-1:0] & byte_mask[BTN_WIDTH-1:0]);
            end
            // A new rise beats a simultaneous clear.
            edge_q <= (edge_q & ~edge_clr) | btn_rise;
            irq    <= |(edge_q & irq_en);
        end
    end

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Self-checking bench for iomem_gpio_bank with a short debounce window.
module tb_iomem_gpio_bank;

    localparam int IN_W  = 16;
    localparam int BTN_W = 5;
    localparam int OUT_W = 16;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam logic [31:0] BASE = 32'h0000_2000;

    logic             clk;
    logic             reset;
    logic             iomem_valid;
    logic             iomem_ready;
    logic [3:0]       iomem_wstrb;
    logic [31:0]      iomem_addr;
    logic [31:0]      iomem_wdata;
    logic [31:0]      iomem_rdata;
    logic [IN_W-1:0]  sw_in;
    logic [BTN_W-1:0] btn_in;
    logic [OUT_W-1:0] gpio_out;
    logic             irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];

    iomem_gpio_bank #(
        .BASE_ADDR      (BASE),
        .IN_WIDTH       (IN_W),
        .BTN_WIDTH      (BTN_W),
        .OUT_WIDTH      (OUT_W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .sw_in      (sw_in),
        .btn_in     (btn_in),
        .gpio_out   (gpio_out),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request, holds valid through the ready cycle plus one, and reports what came back.
    task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic got, output logic [31:0] rd, output int rcyc);
        got  = 1'b0;
        rd   = '0;
        rcyc = 0;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            rd = iomem_rdata;
            if (iomem_ready) begin
                got  = 1'b1;
                rcyc = 1;
                break;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
            if (iomem_ready) rcyc++;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_wdata = '0;
    endtask

    task automatic test_reset();
        logic        got;
        logic [31:0] rd;
        logic [31:0] exp;
        int          rc;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (iomem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0h want 0", iomem_ready); end
        n_checks++;
        if (iomem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %08h want 00000000", iomem_rdata); end
        n_checks++;
        if (gpio_out !== '0) begin n_fail++; $display("FAIL reset_gpio: got %04h want 0000", gpio_out); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0h want 0", irq); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        do_access(BASE + 32'h0C, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL reset_edge_read: got %08h want %08h", rd, exp); end
    endtask

    task automatic test_out();
        logic        got;
        logic [31:0] rd;
        logic [31:0] exp;
        int          rc;
        do_access(BASE, 32'h0000_A5A5, 4'b0001, got, rd, rc);
        n_checks++;
        if (!got || rc !== 1) begin n_fail++; $display("FAIL out_write_ready: got %0d cycles want 1", rc); end
        n_checks++;
        if (gpio_out !== 16'h00A5) begin n_fail++; $display("FAIL out_gpio_byte0: got %04h want 00a5", gpio_out); end
        exp_q.push_back(32'h0000_00A5);
        do_access(BASE, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL out_read: got %08h want %08h", rd, exp); end
        // Full write: returns the old value, upper bits beyond the field dropped.
        exp_q.push_back(32'h0000_00A5);
        do_access(BASE + 32'h1, 32'hFFFF_1234, 4'b1111, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL out_prewrite_read: got %08h want %08h", rd, exp); end
        n_checks++;
        if (gpio_out !== 16'h1234) begin n_fail++; $display("FAIL out_gpio_full: got %04h want 1234", gpio_out); end
        do_access(BASE, 32'h0000_BE00, 4'b0010, got, rd, rc);
        n_checks++;
        if (gpio_out !== 16'hBE34) begin n_fail++; $display("FAIL out_gpio_byte1: got %04h want be34", gpio_out); end
    endtask

    task automatic test_switches();
        logic        got;
        logic [31:0] rd;
        logic [31:0] exp;
        int          rc;
        sw_in = 16'h1234;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        exp_q.push_back(32'h0000_1234);
        do_access(BASE + 32'h4, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL sw_read: got %08h want %08h", rd, exp); end
        n_checks++;
        if (rc !== 1) begin n_fail++; $display("FAIL sw_ready_len: got %0d want 1", rc); end
        do_access(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, got, rd, rc);
        exp_q.push_back(32'h0000_1234);
        do_access(BASE + 32'h4, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL sw_ro_write: got %08h want %08h", rd, exp); end
    endtask

    task automatic test_debounce();
        logic        got;
        logic [31:0] rd;
        logic [31:0] exp;
        int          rc;
        btn_in[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btn_in[2] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        do_access(BASE + 32'h8, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL glitch_btn: got %08h want %08h", rd, exp); end
        exp_q.push_back(32'h0);
        do_access(BASE + 32'hC, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL glitch_edge: got %08h want %08h", rd, exp); end
        btn_in[2] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        exp_q.push_back(32'h4);
        do_access(BASE + 32'h8, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL held_btn: got %08h want %08h", rd, exp); end
        exp_q.push_back(32'h4);
        do_access(BASE + 32'hC, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL held_edge: got %08h want %08h", rd, exp); end
    endtask

    task automatic test_irq();
        logic        got;
        logic [31:0] rd;
        logic [31:0] exp;
        int          rc;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %0h want 0", irq); end
        do_access(BASE + 32'h10, 32'h0000_0004, 4'b0001, got, rd, rc);
        @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enabled: got %0h want 1", irq); end
        do_access(BASE + 32'hC, 32'h0000_0004, 4'b0001, got, rd, rc);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_clear: got %0h want 0", irq); end
        exp_q.push_back(32'h0);
        do_access(BASE + 32'hC, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL edge_cleared: got %08h want %08h", rd, exp); end
        btn_in[2] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        do_access(BASE + 32'h8, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL btn_released: got %08h want %08h", rd, exp); end
        // Level rises on the sixth edge after the input change, the same edge the clear lands on.
        btn_in[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        do_access(BASE + 32'hC, 32'h0000_0004, 4'b0001, got, rd, rc);
        exp_q.push_back(32'h4);
        do_access(BASE + 32'hC, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL set_beats_clear: got %08h want %08h", rd, exp); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_reraised: got %0h want 1", irq); end
    endtask

    task automatic test_window();
        logic        got;
        logic [31:0] rd;
        logic [31:0] exp;
        int          rc;
        do_access(32'h0000_3000, 32'hFFFF_FFFF, 4'hF, got, rd, rc);
        n_checks++;
        if (got !== 1'b0) begin n_fail++; $display("FAIL miss_ready: got %0h want 0", got); end
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL miss_rdata: got %08h want 00000000", rd); end
        do_access(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, got, rd, rc);
        n_checks++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL reserved_ready: got %0h want 1", got); end
        exp_q.push_back(32'h0);
        do_access(BASE + 32'h18, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL reserved_read: got %08h want %08h", rd, exp); end
        exp_q.push_back(32'h0000_BE34);
        do_access(BASE, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL out_untouched: got %08h want %08h", rd, exp); end
    endtask

    task automatic test_reset_mid_access();
        logic        got;
        logic [31:0] rd;
        logic [31:0] exp;
        int          rc;
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %0h want 1", irq); end
        iomem_valid = 1'b1;
        iomem_addr  = BASE;
        iomem_wdata = 32'h0000_0077;
        iomem_wstrb = 4'hF;
        @(posedge clk);
        #1;
        n_checks++;
        if (iomem_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_up: got %0h want 1", iomem_ready); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (iomem_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_drop: got %0h want 0", iomem_ready); end
        n_checks++;
        if (gpio_out !== '0) begin n_fail++; $display("FAIL mid_gpio: got %04h want 0000", gpio_out); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %0h want 0", irq); end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        do_access(BASE + 32'h10, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL post_irqen: got %08h want %08h", rd, exp); end
        do_access(BASE, 32'h0000_005A, 4'hF, got, rd, rc);
        exp_q.push_back(32'h0000_005A);
        do_access(BASE, 32'h0, 4'h0, got, rd, rc);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== exp) begin n_fail++; $display("FAIL post_out_read: got %08h want %08h", rd, exp); end
        n_checks++;
        if (gpio_out !== 16'h005A) begin n_fail++; $display("FAIL post_gpio: got %04h want 005a", gpio_out); end
    endtask

    initial begin
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        sw_in       = '0;
        btn_in      = '0;
        test_reset();
        test_out();
        test_switches();
        test_debounce();
        test_irq();
        test_window();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
